reg_writeback: RTL and testbench

- Write-side front end of the core's register file: arbitrates results from the ALU and load/store (LSU) paths into the file's single write port.
- Tracks destination registers with outstanding results in a 32-bit scoreboard; decode uses it for RAW/WAW stalls.
- Outputs drive the register file's write_en/rd_addr/rd_data directly; the scoreboard answers decode's rs1/rs2 queries.

---
 rtl/reg_writeback_pkg.sv | 14 +
 rtl/wb_scoreboard.sv | 39 +++
 rtl/reg_writeback.sv | 135 +++++++++++++
 tb/tb_reg_writeback.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared types for the register-file write side: data/address types,
// the arbiter source select and the hard-wired zero register.
package reg_writeback_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_MEM
  } wb_src_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_scoreboard.sv
// Busy vector of destination registers with pending results.
// Priority at an edge: flush > set > clear; x0 is never marked busy.
module wb_scoreboard
  import reg_writeback_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en_i,
  input  reg_addr_t set_addr_i,
  input  logic      clr_en_i,
  input  reg_addr_t clr_addr_i,
  input  logic      flush_i,
  input  reg_addr_t q1_addr_i,
  input  reg_addr_t q2_addr_i,
  input  reg_addr_t q3_addr_i,
  output logic      q1_busy_o,
  output logic      q2_busy_o,
  output logic      q3_busy_o
);
  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i && set_addr_i != REG_ZERO) busy_d[set_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign q1_busy_o = busy_q[q1_addr_i];
  assign q2_busy_o = busy_q[q2_addr_i];
  assign q3_busy_o = busy_q[q3_addr_i];
endmodule

// File: rtl/reg_writeback.sv
// Arbitrates ALU and LSU results into the single register-file write port
// and tracks outstanding destinations. `REG_WRITEBACK_BYPASS_EN adds forwarding.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MEM_PRIO_AGE = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_valid,
  input  reg_addr_t issue_rd_addr,
  output logic      issue_ready,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
`ifdef REG_WRITEBACK_BYPASS_EN
  output logic      rs1_fwd_valid,
  output logic      rs2_fwd_valid,
  output word_t     rs1_fwd_data,
  output word_t     rs2_fwd_data,
`endif
  input  logic      alu_valid,
  input  reg_addr_t alu_rd_addr,
  input  word_t     alu_data,
  output logic      alu_ready,
  input  logic      mem_valid,
  input  reg_addr_t mem_rd_addr,
  input  word_t     mem_data,
  output logic      mem_ready,
  input  logic      flush,
  output logic      write_en,
  output reg_addr_t rd_addr,
  output word_t     rd_data
);
  localparam int AW = (MEM_PRIO_AGE > 0) ? $clog2(MEM_PRIO_AGE + 1) : 1;
  localparam logic [AW-1:0] AGE_MAX = AW'(MEM_PRIO_AGE);

  logic [AW-1:0] age_q, age_d;
  logic          override, alu_xfer, mem_xfer;
  wb_src_t       src;
  reg_addr_t     win_addr;
  word_t         win_data;
  logic          wen_q, wen_d;
  reg_addr_t     addr_q, addr_d;
  word_t         data_q, data_d;
  logic          sb_rs1, sb_rs2, sb_iss;

  // With MEM_PRIO_AGE==0, AGE_MAX is 0 and the counter never moves, so gate explicitly.
  assign override  = (MEM_PRIO_AGE != 0) && (age_q == AGE_MAX);
  assign alu_ready = !override;
  assign mem_ready = mem_valid && (!alu_valid || override);
  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;

  always_comb begin
    src      = WB_SRC_NONE;
    win_addr = REG_ZERO;
    win_data = '0;
    if (mem_xfer)      src = WB_SRC_MEM;
    else if (alu_xfer) src = WB_SRC_ALU;
    case (src)
      WB_SRC_ALU: begin win_addr = alu_rd_addr; win_data = alu_data; end
      WB_SRC_MEM: begin win_addr = mem_rd_addr; win_data = mem_data; end
      default:    ;
    endcase
  end

  always_comb begin
    age_d = age_q;
    if (flush || mem_xfer)                          age_d = '0;
    else if (mem_valid && !mem_ready && age_q != AGE_MAX) age_d = age_q + 1'b1;
  end

  // A result to x0 still updates address/data but never strobes the file.
  always_comb begin
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (src != WB_SRC_NONE) begin
      wen_d  = (win_addr != REG_ZERO);
      addr_d = win_addr;
      data_d = win_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q  <= '0;
      wen_q  <= 1'b0;
      addr_q <= REG_ZERO;
      data_q <= '0;
    end else begin
      age_q  <= age_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign write_en = wen_q;
  assign rd_addr  = addr_q;
  assign rd_data  = data_q;

  assign issue_ready = (issue_rd_addr == REG_ZERO) || !sb_iss;

  wb_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (issue_valid && issue_ready),
    .set_addr_i (issue_rd_addr),
    .clr_en_i   (src != WB_SRC_NONE),
    .clr_addr_i (win_addr),
    .flush_i    (flush),
    .q1_addr_i  (rs1_addr),
    .q2_addr_i  (rs2_addr),
    .q3_addr_i  (issue_rd_addr),
    .q1_busy_o  (sb_rs1),
    .q2_busy_o  (sb_rs2),
    .q3_busy_o  (sb_iss)
  );

`ifdef REG_WRITEBACK_BYPASS_EN
  assign rs1_fwd_valid = wen_q && (addr_q == rs1_addr) && (rs1_addr != REG_ZERO);
  assign rs2_fwd_valid = wen_q && (addr_q == rs2_addr) && (rs2_addr != REG_ZERO);
  assign rs1_fwd_data  = data_q;
  assign rs2_fwd_data  = data_q;
  assign rs1_busy      = (rs1_addr != REG_ZERO) && sb_rs1 && !rs1_fwd_valid;
  assign rs2_busy      = (rs2_addr != REG_ZERO) && sb_rs2 && !rs2_fwd_valid;
`else
  assign rs1_busy      = (rs1_addr != REG_ZERO) && sb_rs1;
  assign rs2_busy      = (rs2_addr != REG_ZERO) && sb_rs2;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Directed + random bench for reg_writeback against an array-based reference model.
module tb_reg_writeback;
  localparam int AGE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 0, flush = 0;
  logic [4:0]  issue_rd_addr = 0, rs1_addr = 0, rs2_addr = 0;
  logic        issue_ready, rs1_busy, rs2_busy;
  logic        alu_valid = 0, mem_valid = 0, alu_ready, mem_ready;
  logic [4:0]  alu_rd_addr = 0, mem_rd_addr = 0;
  logic [31:0] alu_data = 0, mem_data = 0;
  logic        write_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
`ifdef REG_WRITEBACK_BYPASS_EN
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

  always #5 clk = ~clk;

  reg_writeback #(.NUM_REGS(32), .MEM_PRIO_AGE(AGE)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd_addr(issue_rd_addr), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef REG_WRITEBACK_BYPASS_EN
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
    .alu_valid(alu_valid), .alu_rd_addr(alu_rd_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd_addr(mem_rd_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .flush(flush), .write_en(write_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int checks = 0, errors = 0;

  // Reference model state
  bit          mb[32];
  int          mage;
  bit          mwen;
  logic [4:0]  maddr;
  logic [31:0] mdata;
  bit          last_ax, last_mx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registered outputs.
  task automatic cycle();
    bit ovr, e_ar, e_mr, ax, mx, iss_ok, fw1, fw2;
    logic [4:0]  wa;
    logic [31:0] wd;
    @(negedge clk);
    ovr    = (AGE != 0) && (mage == AGE);
    e_ar   = !ovr;
    e_mr   = mem_valid && (!alu_valid || ovr);
    iss_ok = (issue_rd_addr == 0) || !mb[issue_rd_addr];
    fw1 = 0; fw2 = 0;
`ifdef REG_WRITEBACK_BYPASS_EN
    fw1 = mwen && maddr == rs1_addr && rs1_addr != 0;
    fw2 = mwen && maddr == rs2_addr && rs2_addr != 0;
`endif
    if (!rst) begin
      chk("issue_ready", 32'(issue_ready), 32'(iss_ok));
      chk("rs1_busy", 32'(rs1_busy), 32'(rs1_addr != 0 && mb[rs1_addr] && !fw1));
      chk("rs2_busy", 32'(rs2_busy), 32'(rs2_addr != 0 && mb[rs2_addr] && !fw2));
      chk("alu_ready", 32'(alu_ready), 32'(e_ar));
      chk("mem_ready", 32'(mem_ready), 32'(e_mr));
`ifdef REG_WRITEBACK_BYPASS_EN
      chk("rs1_fwd_valid", 32'(rs1_fwd_valid), 32'(fw1));
      chk("rs2_fwd_valid", 32'(rs2_fwd_valid), 32'(fw2));
      if (fw1) chk("rs1_fwd_data", rs1_fwd_data, mdata);
      if (fw2) chk("rs2_fwd_data", rs2_fwd_data, mdata);
`endif
    end
    ax = alu_valid && e_ar;
    mx = mem_valid && e_mr;
    if (rst) begin
      foreach (mb[i]) mb[i] = 0;
      mage = 0; mwen = 0; maddr = 0; mdata = 0; ax = 0; mx = 0;
    end else begin
      wa = mx ? mem_rd_addr : alu_rd_addr;
      wd = mx ? mem_data : alu_data;
      if (ax || mx) begin
        mwen = (wa != 0); maddr = wa; mdata = wd;
        mb[wa] = 0;
      end else mwen = 0;
      if (issue_valid && iss_ok && issue_rd_addr != 0) mb[issue_rd_addr] = 1;
      if (flush) foreach (mb[i]) mb[i] = 0;
      if (flush || mx) mage = 0;
      else if (mem_valid && !e_mr && mage < AGE) mage++;
    end
    last_ax = ax; last_mx = mx;
    @(posedge clk); #1;
    chk("write_en", 32'(write_en), 32'(mwen));
    chk("rd_addr", 32'(rd_addr), 32'(maddr));
    chk("rd_data", rd_data, mdata);
  endtask

  initial begin
    // Reset with a pending ALU result
    rst = 1; alu_valid = 1; alu_rd_addr = 3; alu_data = 32'h11;
    cycle(); cycle();
    rst = 0; alu_valid = 0; issue_rd_addr = 5; rs1_addr = 5; #1;
    chk("rst_write_en", 32'(write_en), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_issue_ready", 32'(issue_ready), 1);
    chk("rst_rs1_busy", 32'(rs1_busy), 0);

    // Basic RAW on x5
    issue_valid = 1; cycle();
    issue_valid = 0; #1;
    chk("raw_rs1_busy", 32'(rs1_busy), 1);
    chk("raw_waw_ready", 32'(issue_ready), 0);
    alu_valid = 1; alu_rd_addr = 5; alu_data = 32'hDEADBEEF; #1;
    chk("raw_alu_ready", 32'(alu_ready), 1);
    cycle();
    alu_valid = 0; #1;
    chk("raw_wen", 32'(write_en), 1);
    chk("raw_addr", 32'(rd_addr), 5);
    chk("raw_data", rd_data, 32'hDEADBEEF);
    chk("raw_rs1_clear", 32'(rs1_busy), 0);
    cycle();

    // Contention: ALU wins AGE cycles, then the LSU override
    alu_valid = 1; alu_rd_addr = 2; mem_valid = 1; mem_rd_addr = 7; mem_data = 32'h1234;
    for (int i = 0; i < AGE; i++) begin
      alu_data = 32'hA0 + 32'(i); #1;
      chk("age_alu_wins", 32'(alu_ready), 1);
      chk("age_mem_wait", 32'(mem_ready), 0);
      cycle();
    end
    #1;
    chk("age_mem_ready", 32'(mem_ready), 1);
    chk("age_alu_blocked", 32'(alu_ready), 0);
    cycle();
    mem_valid = 0; #1;
    chk("age_wen", 32'(write_en), 1);
    chk("age_addr", 32'(rd_addr), 7);
    chk("age_data", rd_data, 32'h1234);
    mem_valid = 1; #1;
    chk("age_reset", 32'(mem_ready), 0);
    mem_valid = 0; alu_valid = 0; #1;
    cycle();

    // x0 destination
    issue_valid = 1; issue_rd_addr = 0; rs1_addr = 0; #1;
    chk("x0_issue_ready", 32'(issue_ready), 1);
    cycle();
    issue_valid = 0; #1;
    chk("x0_busy", 32'(rs1_busy), 0);
    alu_valid = 1; alu_rd_addr = 0; alu_data = 32'hFFFFFFFF; #1;
    chk("x0_alu_ready", 32'(alu_ready), 1);
    cycle();
    alu_valid = 0; #1;
    chk("x0_wen", 32'(write_en), 0);

    // Same-cycle commit and issue on x9: set wins
    alu_valid = 1; alu_rd_addr = 9; alu_data = 32'h99;
    issue_valid = 1; issue_rd_addr = 9; rs1_addr = 9;
    cycle();
    alu_valid = 0; issue_valid = 0; #1;
    chk("sim_wen", 32'(write_en), 1);
    chk("sim_addr", 32'(rd_addr), 9);
    chk("sim_busy", 32'(rs1_busy), 1);

    // Flush with same-cycle issue, then LSU drain
    issue_valid = 1; issue_rd_addr = 3; cycle();
    issue_rd_addr = 4; cycle();
    issue_rd_addr = 6; flush = 1; cycle();
    issue_valid = 0; flush = 0; rs1_addr = 3; rs2_addr = 4; #1;
    chk("flush_x3", 32'(rs1_busy), 0);
    chk("flush_x4", 32'(rs2_busy), 0);
    rs1_addr = 6; rs2_addr = 9; #1;
    chk("flush_x6", 32'(rs1_busy), 0);
    chk("flush_x9", 32'(rs2_busy), 0);
    mem_valid = 1; mem_rd_addr = 3; mem_data = 32'h33; cycle();
    mem_valid = 0; #1;
    chk("drain_wen", 32'(write_en), 1);
    chk("drain_addr", 32'(rd_addr), 3);

    // Commit cycle visibility of x5 on rs2
    issue_valid = 1; issue_rd_addr = 5; cycle();
    issue_valid = 0; alu_valid = 1; alu_rd_addr = 5; alu_data = 32'hC0FFEE; rs2_addr = 5;
    cycle();
    alu_valid = 0; #1;
    chk("commit_rs2_busy", 32'(rs2_busy), 0);
`ifdef REG_WRITEBACK_BYPASS_EN
    chk("byp_fwd_valid", 32'(rs2_fwd_valid), 1);
    chk("byp_fwd_data", rs2_fwd_data, 32'hC0FFEE);
`endif
    cycle();

    // Random traffic honouring the valid/ready hold rule
    for (int n = 0; n < 500; n++) begin
      if (!alu_valid || last_ax) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd_addr = 5'($urandom_range(0, 7));
        alu_data = $urandom;
      end
      if (!mem_valid || last_mx) begin
        mem_valid = ($urandom_range(0, 3) != 0);
        mem_rd_addr = 5'($urandom_range(0, 7));
        mem_data = $urandom;
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd_addr = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      flush = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 0; flush = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
